// File: rtl/bf_print_uart.sv
// Byte FIFO plus 8N1 UART transmitter for the bf core's print output.
// Bytes are queued on each print strobe and shifted out LSB first with no idle gap between frames.
module bf_print_uart #(
    parameter int CLK_DIV    = 217,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  print,
    input  logic [7:0]            out,
    input  logic                  ovf_clr,
    output logic                  tx,
    output logic                  full,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]      DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DEPTH_LOG2:0]   DEPTH_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    state_t                state;
    state_t                state_nxt;
    logic [DIV_W-1:0]      div;
    logic [DIV_W-1:0]      div_nxt;
    logic [2:0]            bit_cnt;
    logic [2:0]            bit_nxt;
    logic [7:0]            shreg;
    logic [7:0]            sh_nxt;
    logic                  tx_nxt;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic                  div_end;
    logic                  not_empty;

    assign not_empty = (count != '0);
    assign div_end   = (div == DIV_LAST);
    assign full      = (count == DEPTH_FULL);
    assign busy      = (state != IDLE) || not_empty;

    // A pop frees a slot in the same cycle, so a push at full is still accepted then.
    assign push = print && (!full || pop);
    assign drop = print && full && !pop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (not_empty) state_nxt = START;
            START:   if (div_end) state_nxt = DATA;
            DATA:    if (div_end && (bit_cnt == 3'd7)) state_nxt = STOP;
            STOP:    if (div_end) state_nxt = not_empty ? START : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop     = 1'b0;
        div_nxt = div;
        bit_nxt = bit_cnt;
        sh_nxt  = shreg;
        tx_nxt  = 1'b1;
        case (state)
            IDLE: begin
                if (not_empty) begin
                    pop     = 1'b1;
                    sh_nxt  = mem[rd_ptr];
                    div_nxt = '0;
                    bit_nxt = '0;
                end
            end
            START: begin
                div_nxt = div_end ? '0 : div + 1'b1;
            end
            DATA: begin
                if (div_end) begin
                    div_nxt = '0;
                    sh_nxt  = {1'b0, shreg[7:1]};
                    if (bit_cnt != 3'd7) bit_nxt = bit_cnt + 1'b1;
                end else begin
                    div_nxt = div + 1'b1;
                end
            end
            STOP: begin
                if (div_end) begin
                    div_nxt = '0;
                    if (not_empty) begin
                        pop     = 1'b1;
                        sh_nxt  = mem[rd_ptr];
                        bit_nxt = '0;
                    end
                end else begin
                    div_nxt = div + 1'b1;
                end
            end
            default: ;
        endcase
        // tx is registered from the upcoming state so the line has no combinational path.
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = sh_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx       <= 1'b1;
            div      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            tx      <= tx_nxt;
            div     <= div_nxt;
            bit_cnt <= bit_nxt;
            shreg   <= sh_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= out;
    end

endmodule

// File: tb/tb_bf_print_uart.sv
// Bench for bf_print_uart: queue/timeline reference model, UART line decoder, directed and random traffic.
module tb_bf_print_uart;

    localparam int CLK_DIV    = 4;
    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int FRAME      = 10 * CLK_DIV;

    logic                clock   = 1'b0;
    logic                reset_n = 1'b1;
    logic                print   = 1'b0;
    logic [7:0]          out     = 8'h00;
    logic                ovf_clr = 1'b0;
    logic                tx;
    logic                full;
    logic                busy;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;

    always #5 clock = ~clock;

    bf_print_uart #(.CLK_DIV(CLK_DIV), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .print    (print),
        .out      (out),
        .ovf_clr  (ovf_clr),
        .tx       (tx),
        .full     (full),
        .busy     (busy),
        .count    (count),
        .overflow (overflow)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: queue of waiting bytes plus the remaining cycles of the frame on the line.
    logic [7:0] m_q[$];
    int         m_rem = 0;
    logic [7:0] m_cur = 8'h00;
    logic       m_ovf = 1'b0;
    logic [7:0] sent_q[$];
    logic [7:0] rx_q[$];
    int         rx_pos = -1;
    logic [7:0] rx_byte = 8'h00;

    typedef struct {
        logic       p;
        logic [7:0] d;
        logic       c;
        int         exp_count;
        logic       exp_full;
        logic       exp_ovf;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_tx();
        int p;
        int idx;
        if (m_rem == 0) return 1'b1;
        p   = FRAME - m_rem;
        idx = p / CLK_DIV;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return m_cur[idx-1];
    endfunction

    task automatic model_edge(input logic p, input logic [7:0] d, input logic c);
        logic popped;
        logic dropped;
        popped  = 1'b0;
        dropped = 1'b0;
        if ((m_rem == 0 || m_rem == 1) && m_q.size() > 0) begin
            m_cur  = m_q.pop_front();
            popped = 1'b1;
        end
        if (p) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(d);
                sent_q.push_back(d);
            end else begin
                dropped = 1'b1;
                m_ovf   = 1'b1;
            end
        end
        if (c && !dropped) m_ovf = 1'b0;
        if (popped) m_rem = FRAME;
        else if (m_rem > 0) m_rem--;
    endtask

    task automatic rx_sample();
        if (rx_pos < 0) begin
            if (tx == 1'b0) rx_pos = 0;
        end else begin
            rx_pos++;
        end
        if (rx_pos >= 6 && rx_pos <= 34 && ((rx_pos - 2) % 4) == 0)
            rx_byte[(rx_pos - 6) / 4] = tx;
        if (rx_pos == 38) begin
            chk("rx_stop_bit", tx, 1);
            rx_q.push_back(rx_byte);
            rx_pos = -1;
        end
    endtask

    task automatic cycle(input logic p, input logic [7:0] d, input logic c);
        print   = p;
        out     = d;
        ovf_clr = c;
        @(posedge clock);
        model_edge(p, d, c);
        #1;
        chk("tx", tx, model_tx());
        chk("count", count, m_q.size());
        chk("full", full, m_q.size() == DEPTH);
        chk("busy", busy, (m_rem > 0) || (m_q.size() > 0));
        chk("overflow", overflow, m_ovf);
        rx_sample();
    endtask

    task automatic do_reset();
        print   = 1'b0;
        ovf_clr = 1'b0;
        reset_n = 1'b0;
        #1;
        m_q.delete();
        sent_q.delete();
        rx_q.delete();
        m_rem  = 0;
        m_ovf  = 1'b0;
        rx_pos = -1;
        chk("rst_tx", tx, 1);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        @(posedge clock);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic drain_and_compare(input string name);
        int n;
        n = 0;
        while ((m_rem > 0 || m_q.size() > 0) && n < 2000) begin
            cycle(1'b0, 8'h00, 1'b0);
            n++;
        end
        chk({name, "_drain_idle"}, busy, 0);
        cycle(1'b0, 8'h00, 1'b0);
        chk({name, "_rx_len"}, rx_q.size(), sent_q.size());
        for (int i = 0; i < sent_q.size() && i < rx_q.size(); i++)
            chk({name, "_rx_byte"}, rx_q[i], sent_q[i]);
        sent_q.delete();
        rx_q.delete();
    endtask

    initial begin
        logic [7:0] pat;
        int         n;
        int         peak;
        int         exp_tx;
        int         idx;
        int         gap;

        tbl[0] = '{1'b1, 8'h10, 1'b0, 1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'h11, 1'b0, 1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 8'h12, 1'b0, 2, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 8'h13, 1'b0, 3, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 8'h14, 1'b0, 4, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 8'h15, 1'b0, 4, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 4, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 4, 1'b1, 1'b0};

        #2;
        do_reset();

        // Nothing transmits after reset without a push.
        for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 1'b0);

        // Single byte 0x41 against its hand-written waveform.
        pat = 8'h41;
        cycle(1'b1, 8'h41, 1'b0);
        for (int i = 0; i <= FRAME; i++) begin
            cycle(1'b0, 8'h00, 1'b0);
            idx = i / CLK_DIV;
            if (i == FRAME || idx == 9) exp_tx = 1;
            else if (idx == 0) exp_tx = 0;
            else exp_tx = pat[idx-1];
            chk("single_tx", tx, exp_tx);
            if (i == FRAME - 1) chk("single_busy_last", busy, 1);
            if (i == FRAME) chk("single_busy_end", busy, 0);
        end
        drain_and_compare("single");

        // Back-to-back frames with no idle gap.
        cycle(1'b1, 8'h48, 1'b0);
        peak = count;
        cycle(1'b1, 8'h69, 1'b0);
        if (count > peak) peak = count;
        n = 0;
        while (busy && n < 500) begin
            cycle(1'b0, 8'h00, 1'b0);
            if (count > peak) peak = count;
            n++;
        end
        chk("b2b_len", n, 2 * FRAME);
        chk("b2b_peak", peak, 1);
        drain_and_compare("b2b");

        // Overflow table, then clear.
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].p, tbl[i].d, tbl[i].c);
            chk("tbl_count", count, tbl[i].exp_count);
            chk("tbl_full", full, tbl[i].exp_full);
            chk("tbl_overflow", overflow, tbl[i].exp_ovf);
        end

        // Push at full exactly on the stop-end edge.
        n = 0;
        while (m_rem != 1 && n < 200) begin
            cycle(1'b0, 8'h00, 1'b0);
            n++;
        end
        chk("fullpop_reached", m_rem, 1);
        cycle(1'b1, 8'h77, 1'b0);
        chk("fullpop_count", count, 4);
        chk("fullpop_overflow", overflow, 0);
        drain_and_compare("overflow");

        // Reset during data bit 3.
        cycle(1'b1, 8'hA5, 1'b0);
        cycle(1'b1, 8'h3C, 1'b0);
        n = 0;
        while (m_rem != FRAME - 4 * CLK_DIV - 2 && n < 200) begin
            cycle(1'b0, 8'h00, 1'b0);
            n++;
        end
        chk("midrst_reached", m_rem, FRAME - 4 * CLK_DIV - 2);
        do_reset();
        for (int i = 0; i < 100; i++) cycle(1'b0, 8'h00, 1'b0);
        chk("midrst_no_frame", rx_q.size(), 0);

        // Ten bytes with gaps; pointers wrap.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
            gap = $urandom_range(0, 60);
            for (int j = 0; j < gap; j++) cycle(1'b0, 8'h00, 1'b0);
        end
        drain_and_compare("wrap");

        // Random traffic.
        for (int i = 0; i < 600; i++)
            cycle(($urandom_range(0, 99) < 12), 8'($urandom_range(0, 255)),
                  ($urandom_range(0, 99) < 5));
        drain_and_compare("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bf_print_uart.md
BF_PRINT_UART -- requirements
Module: bf_print_uart

Interface
REQ-001 Parameter CLK_DIV, default 217, sets the clock cycles per UART bit (25 MHz / 115200); legal range 2..65535.
REQ-002 Parameter DEPTH_LOG2, default 4, sets the FIFO depth; depth = 2^DEPTH_LOG2 = 16 entries.
REQ-003 Port clock, input, 1 bit, is the single clock; the block is in the same domain as the bf core.
REQ-004 Port reset_n, input, 1 bit, is the asynchronous active-low reset.
REQ-005 Port print, input, 1 bit, is the bf print strobe; one byte is pushed per cycle that it is high.
REQ-006 Port out, input, 8 bits, is the character from bf, sampled when print=1.
REQ-007 Port ovf_clr, input, 1 bit, clears the sticky overflow flag synchronously.
REQ-008 Port tx, output, 1 bit, is the UART serial line (8N1), idle high.
REQ-009 Port full, output, 1 bit, is high when the FIFO count equals the depth.
REQ-010 Port busy, output, 1 bit, is high when the FSM is not IDLE or the FIFO is non-empty.
REQ-011 Port count, output, DEPTH_LOG2+1 bits, is the current FIFO occupancy.
REQ-012 Port overflow, output, 1 bit, is a sticky flag set when a push is dropped.

Function
REQ-013 The FIFO SHALL be circular with write/read pointers wrapping modulo depth; count is registered.
REQ-014 Push: print=1 and (not full, or a pop occurs the same cycle) -> the byte is stored and the write pointer advances.
REQ-015 Push with full=1 and no simultaneous pop -> the byte is dropped, overflow is set, and pointers and count are unchanged.
REQ-016 Simultaneous push and pop -> both are performed and count is unchanged; this applies at full and at any level.
REQ-017 Pop when empty SHALL never occur; the FSM pops only when count != 0.
REQ-018 ovf_clr=1 clears overflow; if a drop occurs in the same cycle, set wins.
REQ-019 FSM states are IDLE, START, DATA, STOP; tx is registered (no combinational path to tx).
REQ-020 IDLE: tx=1; if count != 0, pop the head into the shift register, clear the bit counter and divider, and go to START.
REQ-021 START: tx=0 for CLK_DIV cycles, then go to DATA.
REQ-022 DATA: 8 bits are sent LSB first, CLK_DIV cycles each; the shift register shifts right per bit; after bit 7, go to STOP.
REQ-023 STOP: tx=1 for CLK_DIV cycles; at the end, if count != 0, pop and go to START directly (no idle gap), else go to IDLE.
REQ-024 Frame length SHALL be exactly 10*CLK_DIV cycles; back-to-back frames SHALL have zero extra idle cycles.
REQ-025 Latency: a byte pushed at edge N into an empty FIFO with the FSM in IDLE SHALL drive tx low after edge N+1.
REQ-026 A byte popped in the same cycle as a push (FIFO previously empty) SHALL NOT be forwarded; the pop reads only stored data.
REQ-027 The bit divider counts 0..CLK_DIV-1 and wraps; its width is derived from CLK_DIV.

Reset
REQ-028 While reset_n=0, the block SHALL be held: tx=1, state=IDLE, count=0, pointers=0, overflow=0, full=0, busy=0, shift register and counters=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately (tx=1 asynchronously); queued bytes are discarded.
REQ-030 After reset_n deasserts, no transmission SHALL start until a new push.

Verification (CLK_DIV=4, DEPTH_LOG2=2)
REQ-031 Single byte: push 8'h41 at edge 0 -> tx low from edge 1 for 4 cycles, then 1,0,0,0,0,0,1,0 (4 cycles each), stop high, busy low after 40 cycles.
REQ-032 Back-to-back: push 8'h48, 8'h69 on consecutive cycles -> two frames totalling 80 cycles with no idle gap; count peaks at 1.
REQ-033 Overflow: push 6 bytes in 6 consecutive cycles while the first frame is active -> 1 in flight, 4 queued, 1 dropped; overflow=1 and full=1; ovf_clr clears the flag.
REQ-034 Full with simultaneous pop: fill to 4, then push exactly on the STOP-end edge -> the push is accepted, count stays 4, overflow stays 0.
REQ-035 Reset mid-DATA: pulse reset_n low during bit 3 -> tx=1 at once, count=0, and no further frame is transmitted.
REQ-036 Pointer wrap: stream 10 bytes with gaps -> the received sequence on tx is identical to the pushed sequence.
